// File: rtl/bin_to_bcd_converter_pkg.sv
// Shared sizing, FSM encoding and saturation constant for the binary-to-BCD converter.
package bin_to_bcd_converter_pkg;

    localparam int IN_WIDTH   = 32;
    localparam int DIGITS     = 8;
    localparam int INT_DIGITS = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Shown when the magnitude does not fit in the eight displayed digits.
    localparam logic [31:0] SAT_VALUE = 32'h9999_9999;

endpackage

// File: rtl/bin_to_bcd_converter_if.sv
// Request/result bundle between the CPU/I-O path (master) and the converter (slave).
interface bin_to_bcd_converter_if
    import bin_to_bcd_converter_pkg::*;
#(
    parameter int IF_IN_WIDTH = IN_WIDTH,
    parameter int IF_DIGITS   = DIGITS
);
    logic                     start;
    logic [IF_IN_WIDTH-1:0]   bin_in;
    logic                     signed_mode;
    logic                     busy;
    logic                     done;
    logic [4*IF_DIGITS-1:0]   bcd_out;
    logic                     negative;
    logic                     overflow;

    modport master (
        output start, bin_in, signed_mode,
        input  busy, done, bcd_out, negative, overflow
    );

    modport slave (
        input  start, bin_in, signed_mode,
        output busy, done, bcd_out, negative, overflow
    );
endinterface

// File: rtl/bin_to_bcd_converter_bcd_digit_adjust.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 before the shift.
module bcd_digit_adjust (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);
    assign digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;
endmodule

// File: rtl/bin_to_bcd_converter.sv
// Iterative shift-and-add-3 converter, one input bit per cycle; results are held between conversions.
module bin_to_bcd_converter
    import bin_to_bcd_converter_pkg::*;
#(
    parameter int P_IN_WIDTH   = IN_WIDTH,
    parameter int P_DIGITS     = DIGITS,
    parameter int P_INT_DIGITS = INT_DIGITS
) (
    input  logic                   clk,
    input  logic                   rst,
    bin_to_bcd_converter_if.slave  bus
);
    localparam int ACC_W = 4 * P_INT_DIGITS;
    localparam int OUT_W = 4 * P_DIGITS;
    localparam int CNT_W = $clog2(P_IN_WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(P_IN_WIDTH - 1);

    state_t                  state_reg, state_next;
    logic [P_IN_WIDTH-1:0]   bin_reg, bin_next;
    logic [ACC_W-1:0]        acc_reg, acc_next;
    logic [ACC_W-1:0]        acc_adj;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic                    sign_reg, sign_next;
    logic [OUT_W-1:0]        bcd_reg, bcd_next;
    logic                    neg_reg, neg_next;
    logic                    ovf_reg, ovf_next;
    logic                    done_reg, done_next;

    genvar gi;
    generate
        for (gi = 0; gi < P_INT_DIGITS; gi++) begin : g_adj
            bcd_digit_adjust u_adj (
                .digit_in  (acc_reg[4*gi +: 4]),
                .digit_out (acc_adj[4*gi +: 4])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            bin_reg   <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            sign_reg  <= 1'b0;
            bcd_reg   <= '0;
            neg_reg   <= 1'b0;
            ovf_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            bin_reg   <= bin_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            sign_reg  <= sign_next;
            bcd_reg   <= bcd_next;
            neg_reg   <= neg_next;
            ovf_reg   <= ovf_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        bin_next   = bin_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        sign_next  = sign_reg;
        bcd_next   = bcd_reg;
        neg_next   = neg_reg;
        ovf_next   = ovf_reg;
        done_next  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    sign_next  = bus.signed_mode & bus.bin_in[P_IN_WIDTH-1];
                    // Two's-complement negate; 0x80000000 maps onto itself, which is the right magnitude.
                    bin_next   = sign_next ? (~bus.bin_in + P_IN_WIDTH'(1)) : bus.bin_in;
                    acc_next   = '0;
                    cnt_next   = '0;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {acc_next, bin_next} = {acc_adj, bin_reg} << 1;
                cnt_next = cnt_reg + CNT_W'(1);
                if (cnt_reg == LAST_ITER) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                ovf_next   = |acc_reg[ACC_W-1:OUT_W];
                bcd_next   = ovf_next ? OUT_W'(SAT_VALUE) : acc_reg[OUT_W-1:0];
                neg_next   = sign_reg;
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.busy     = (state_reg != ST_IDLE);
    assign bus.done     = done_reg;
    assign bus.bcd_out  = bcd_reg;
    assign bus.negative = neg_reg;
    assign bus.overflow = ovf_reg;

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Scoreboard bench: expected results are queued at stimulus time and compared on each done pulse.
module tb_bin_to_bcd_converter;
    import bin_to_bcd_converter_pkg::*;

    typedef struct packed {
        logic [31:0] bcd;
        logic        neg;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bin_to_bcd_converter_if bus ();

    bin_to_bcd_converter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    exp_t mon_exp;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   txn_cnt  = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        chk_cnt++;
        if (obs === expv) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    endtask

    // Decimal model built from integer arithmetic, independent of the shift-add datapath.
    function automatic exp_t model(input logic [31:0] v, input logic sm);
        exp_t           e;
        logic           s;
        longint unsigned m;
        s = sm & v[31];
        m = s ? (64'd4294967296 - {32'd0, v}) : {32'd0, v};
        e.neg = s;
        e.ovf = (m > 64'd99999999);
        e.bcd = 32'h0;
        if (e.ovf) e.bcd = 32'h99999999;
        else begin
            for (int i = 0; i < 8; i++) begin
                e.bcd[4*i +: 4] = 4'(m % 10);
                m = m / 10;
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                check_val("sb_nonempty", 64'(sb.size()), 64'd1);
            end else begin
                mon_exp = sb.pop_front();
                txn_cnt++;
                $display("txn %0d: bcd_out=%h negative=%0b overflow=%0b (exp %h/%0b/%0b)",
                         txn_cnt, bus.bcd_out, bus.negative, bus.overflow,
                         mon_exp.bcd, mon_exp.neg, mon_exp.ovf);
                check_val("bcd_out",  64'(bus.bcd_out),  64'(mon_exp.bcd));
                check_val("negative", 64'(bus.negative), 64'(mon_exp.neg));
                check_val("overflow", 64'(bus.overflow), 64'(mon_exp.ovf));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_bcd"},  64'(bus.bcd_out),  64'd0);
        check_val({tag, "_busy"}, 64'(bus.busy),     64'd0);
        check_val({tag, "_done"}, 64'(bus.done),     64'd0);
        check_val({tag, "_neg"},  64'(bus.negative), 64'd0);
        check_val({tag, "_ovf"},  64'(bus.overflow), 64'd0);
    endtask

    // One conversion; optional stray start pulse at cycle pulse_k of the conversion.
    task automatic run_conv(input logic [31:0] v, input logic sm, input int pulse_k);
        int k;
        int busy_cnt;
        @(negedge clk);
        bus.bin_in      = v;
        bus.signed_mode = sm;
        bus.start       = 1'b1;
        sb.push_back(model(v, sm));
        busy_cnt = 0;
        for (k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
            if (pulse_k != 0 && k == pulse_k) begin
                bus.start  = 1'b1;
                bus.bin_in = 32'd4242;
            end
            if (pulse_k != 0 && k == pulse_k + 1) bus.start = 1'b0;
            if (bus.busy) busy_cnt++;
            if (bus.done) break;
        end
        check_val("latency", 64'(k), 64'd34);
        check_val("busy_cycles", 64'(busy_cnt), 64'd33);
        @(negedge clk);
        check_val("done_width", 64'(bus.done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k1, k2, k;
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.bin_in      = 32'd0;
        bus.signed_mode = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;

        run_conv(32'h00BC614E, 1'b0, 0);
        run_conv(32'h00000000, 1'b0, 0);
        run_conv(32'h05F5E0FF, 1'b0, 0);
        run_conv(32'h05F5E100, 1'b0, 0);
        run_conv(32'hFFFFFFFF, 1'b0, 0);
        run_conv(32'hFFFFFFFF, 1'b1, 0);
        run_conv(32'hFFFFFF85, 1'b1, 0);
        run_conv(32'h80000000, 1'b1, 0);
        run_conv(32'h0000007B, 1'b1, 0);

        // Idle reset after a nonzero result must clear the held outputs.
        run_conv(32'h00BC614E, 1'b0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("idle_rst");
        @(negedge clk);
        rst = 1'b0;

        run_conv(32'd987654, 1'b0, 5);

        // Start held through the done cycle: a second conversion starts there.
        @(negedge clk);
        bus.bin_in      = 32'd31415926;
        bus.signed_mode = 1'b0;
        bus.start       = 1'b1;
        sb.push_back(model(32'd31415926, 1'b0));
        sb.push_back(model(32'd31415926, 1'b0));
        k1 = 0;
        k2 = 0;
        for (k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k1 != 0 && k == k1 + 1) bus.start = 1'b0;
            if (bus.done) begin
                if (k1 == 0) k1 = k;
                else begin
                    k2 = k;
                    break;
                end
            end
        end
        check_val("b2b_first", 64'(k1), 64'd34);
        check_val("b2b_gap", 64'(k2 - k1), 64'd34);

        // Abort at cycle 10 of a conversion.
        @(negedge clk);
        bus.bin_in      = 32'h00BC614E;
        bus.signed_mode = 1'b0;
        bus.start       = 1'b1;
        sb.push_back(model(32'h00BC614E, 1'b0));
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        check_val("pre_abort_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        sb.delete();
        #1;
        check_reset_outputs("abort");
        repeat (3) begin
            @(negedge clk);
            check_val("abort_no_done", 64'(bus.done), 64'd0);
        end
        rst = 1'b0;
        repeat (40) begin
            @(negedge clk);
            check_val("post_abort_quiet", 64'({bus.done, bus.busy}), 64'd0);
        end
        run_conv(32'h00BC614E, 1'b0, 0);

        repeat (2) @(negedge clk);
        check_val("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_converter.md
# bin_to_bcd_converter

Sequential binary-to-BCD converter feeding the 8-digit seven-segment presenter. It takes a 32-bit binary value from the CPU or I/O path and converts it with the iterative shift-and-add-3 (double dabble) method, one bit per cycle. The result is eight packed BCD nibbles that the display scanner shows directly as decimal. The result register holds steady between conversions, so the display never shows partial values.

## Interface

Parameters:
- IN_WIDTH, 32, binary input width; the iteration count equals IN_WIDTH.
- DIGITS, 8, output BCD digits; bcd_out width is 4*DIGITS.
- INT_DIGITS, 10, internal BCD digits, enough for 2^32-1 = 4,294,967,295.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  conversion request; sampled only in IDLE.
- bin_in  input  32  binary value; sampled on the accepting edge.
- signed_mode  input  1  1 = treat bin_in as two's complement; sampled with start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when the result registers update.
- bcd_out  output  32  packed BCD; digit i is in bits [4i+3:4i], with digit 0 the least significant.
- negative  output  1  result sign (signed mode only).
- overflow  output  1  magnitude exceeds 99,999,999.

## Operation

- FSM states: IDLE, SHIFT, DONE.
- IDLE with start=1 (the accepting edge, E0):
  - load magnitude into the binary shift register;
  - clear the 40-bit BCD accumulator;
  - iteration counter = 0;
  - latch the sign: sign = signed_mode & bin_in[31];
  - go to SHIFT; busy goes to 1.
- Magnitude is bin_in if sign=0, else (~bin_in + 1) truncated to 32 bits. For 0x80000000 the magnitude is 2,147,483,648.
- SHIFT, each cycle:
  - every accumulator digit ≥ 5 gets +3 (4-bit add, no carry out);
  - then {acc, bin} shifts left one bit;
  - counter increments.
- SHIFT ends after the 32nd iteration (counter == IN_WIDTH-1 at that edge) and goes to DONE.
- DONE, at the next edge:
  - overflow = (acc digits 9..8 != 0);
  - bcd_out = overflow ? 0x99999999 (saturate) : acc[31:0];
  - negative = sign;
  - done = 1, busy = 0, go to IDLE.
- start outside IDLE is ignored; no queueing.
- negative=1 with magnitude 0 cannot occur, since sign requires bin_in[31]=1.
- bcd_out, negative and overflow hold their values until the next DONE or reset.

## Timing

- Reset values: state IDLE, busy 0, done 0, bcd_out 0x00000000, negative 0, overflow 0. Accumulator and counter are cleared.
- Latency: accept at E0, iterations at E1..E32, results and done at E33. That is 33 cycles from the accepting edge to done.
- busy is high from after E0 until E33. It deasserts on the same edge that done asserts.
- done is high for exactly one cycle. During that cycle the FSM is in IDLE, so a start in that cycle is accepted. Back-to-back throughput is one conversion per 34 cycles.
- rst asserted mid-conversion aborts immediately:
  - no done pulse;
  - outputs return to their reset values, including bcd_out = 0.

## Structure

- Shared defines/package:
  - IN_WIDTH, DIGITS, INT_DIGITS;
  - FSM state encodings (2-bit: IDLE=0, SHIFT=1, DONE=2);
  - saturation constant 32'h99999999.
- One sub-module: bcd_digit_adjust. It is a combinational 4-bit "if ≥5 add 3" cell, instantiated INT_DIGITS times with generate.
- The FSM, counter and shift registers live in the top module.

## Test plan

- Reset: assert rst mid-idle → bcd_out 0x00000000, busy 0, done 0, negative 0, overflow 0.
- Unsigned basic: bin_in 0x00BC614E (12,345,678), start → busy for 33 cycles, done pulse one cycle, bcd_out 0x12345678, overflow 0. Also bin_in 0 → 0x00000000.
- Overflow boundary:
  - 0x05F5E0FF (99,999,999) → 0x99999999, overflow 0;
  - 0x05F5E100 (100,000,000) → 0x99999999, overflow 1;
  - 0xFFFFFFFF unsigned → overflow 1.
- Signed:
  - 0xFFFFFFFF with signed_mode=1 → bcd_out 0x00000001, negative 1;
  - 0xFFFFFF85 → 0x00000123, negative 1;
  - 0x80000000 → overflow 1, negative 1;
  - 0x7B signed → 0x00000123, negative 0.
- Handshake:
  - start re-pulsed at cycle 5 of a conversion → ignored, result unchanged;
  - start held high through the done cycle → a second conversion is accepted there, and its done arrives 34 cycles after the first done.
- Abort: rst asserted at cycle 10 of a conversion of 12,345,678 → busy 0 immediately, no done, bcd_out 0. A new conversion after rst is released completes correctly.
